// File: rtl/hilo_pkg.sv
// HI/LO register unit: shared widths, write-source indices and divide-tracking states.
package hilo_pkg;

  localparam int HILO_DW   = 32;
  localparam int HILO_NSRC = 3;

  // Write-source slots on the src_* buses
  localparam int SRC_MUL = 0;
  localparam int SRC_DIV = 1;
  localparam int SRC_MT  = 2;

  // Outstanding-divide tracking
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PEND    = 2'd1,
    ST_DISCARD = 2'd2
  } div_st_e;

endpackage

// File: rtl/hilo_src_sel.sv
// Fixed-priority write-source select for one field (HI or LO).
// The lowest index requesting the field wins; o_multi flags that more than one
// source asked for the field in the same cycle.
module hilo_src_sel #(
  parameter int NSRC = 3,
  parameter int DW   = 32
) (
  input  logic [NSRC-1:0]    i_valid,
  input  logic [NSRC-1:0]    i_we,
  input  logic [NSRC*DW-1:0] i_data,
  output logic               o_hit,
  output logic [DW-1:0]      o_data,
  output logic               o_multi
);

  logic [NSRC-1:0] w_req;

  assign w_req = i_valid & i_we;

  // Scan from the highest index down so the lowest requesting index is the last to land.
  always_comb begin
    o_hit   = 1'b0;
    o_data  = '0;
    o_multi = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_req[i]) begin
        if (o_hit) begin
          o_multi = 1'b1;
        end
        o_hit  = 1'b1;
        o_data = i_data[i*DW +: DW];
      end
    end
  end

endmodule

// File: rtl/hilo_reg_unit.sv
// Architectural HI/LO register pair with same-cycle write bypass, outstanding
// divide tracking (stalls MFHI/MFLO while a divide is pending) and flush support.
//
//  state      | meaning
//  -----------+-------------------------------------------------------------
//  ST_IDLE    | no divide outstanding; a divider result here is an error
//  ST_PEND    | divide issued, result not yet back; reads of HI/LO stall
//  ST_DISCARD | divide was flushed; its result will be dropped on arrival
module hilo_reg_unit
  import hilo_pkg::*;
#(
  parameter int DW      = HILO_DW,
  parameter int NSRC    = HILO_NSRC,
  parameter int DIV_IDX = SRC_DIV
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NSRC-1:0]   src_valid,
  input  logic [NSRC-1:0]   src_we_hi,
  input  logic [NSRC-1:0]   src_we_lo,
  input  logic [NSRC*DW-1:0] src_hi,
  input  logic [NSRC*DW-1:0] src_lo,
  input  logic              div_start,
  input  logic              flush,
  input  logic              rd_req,
  output logic [DW-1:0]     hi_out,
  output logic [DW-1:0]     lo_out,
  output logic              stall,
  output logic              div_busy,
  output logic              wr_err
);

  div_st_e         r_state;
  logic            r_busy;
  logic            r_err;
  logic [DW-1:0]   r_hi;
  logic [DW-1:0]   r_lo;

  logic [NSRC-1:0] w_valid_eff;
  logic            w_div_ret;
  logic            w_start;
  logic            w_hit_hi;
  logic            w_hit_lo;
  logic            w_multi_hi;
  logic            w_multi_lo;
  logic            w_multi;
  logic [DW-1:0]   w_data_hi;
  logic [DW-1:0]   w_data_lo;

  assign w_div_ret = src_valid[DIV_IDX];
  // A divide issued in the same cycle as a flush belongs to the squashed path.
  assign w_start   = div_start & ~flush;

  // The divider only writes when its result is actually awaited; IDLE arrivals
  // and results of flushed divides never reach the registers.
  always_comb begin
    w_valid_eff          = src_valid;
    w_valid_eff[DIV_IDX] = src_valid[DIV_IDX] & (r_state == ST_PEND);
  end

  hilo_src_sel #(
    .NSRC (NSRC),
    .DW   (DW)
  ) u_sel_hi (
    .i_valid (w_valid_eff),
    .i_we    (src_we_hi),
    .i_data  (src_hi),
    .o_hit   (w_hit_hi),
    .o_data  (w_data_hi),
    .o_multi (w_multi_hi)
  );

  hilo_src_sel #(
    .NSRC (NSRC),
    .DW   (DW)
  ) u_sel_lo (
    .i_valid (w_valid_eff),
    .i_we    (src_we_lo),
    .i_data  (src_lo),
    .o_hit   (w_hit_lo),
    .o_data  (w_data_lo),
    .o_multi (w_multi_lo)
  );

  assign w_multi = w_multi_hi | w_multi_lo;

  // Architectural HI/LO: load the winning source, otherwise hold.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (w_hit_hi) begin
        r_hi <= w_data_hi;
      end
      if (w_hit_lo) begin
        r_lo <= w_data_lo;
      end
    end
  end

  // Divide tracking FSM with registered busy flag and error pulse.
  // In PEND a returning result takes precedence over a same-cycle flush: the
  // divide has already completed, so there is nothing left to cancel.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_err <= w_multi | w_div_ret;
          if (w_start) begin
            r_state <= ST_PEND;
            r_busy  <= 1'b1;
          end
        end
        ST_PEND: begin
          r_err <= w_multi | w_start;
          if (w_div_ret) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (flush) begin
            r_state <= ST_DISCARD;
            r_busy  <= 1'b1;
          end
        end
        ST_DISCARD: begin
          r_err <= w_multi;
          if (w_div_ret) begin
            if (w_start) begin
              r_state <= ST_PEND;
              r_busy  <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_err   <= w_multi;
        end
      endcase
    end
  end

  // Same-cycle forwarding of the winning write, else the stored value.
  assign hi_out = w_hit_hi ? w_data_hi : r_hi;
  assign lo_out = w_hit_lo ? w_data_lo : r_lo;

  // The completing cycle does not stall: the bypass already carries the result.
  assign stall    = rd_req & (r_state == ST_PEND) & ~w_div_ret;
  assign div_busy = r_busy;
  assign wr_err   = r_err;

endmodule
